// File: rtl/hpu_cmd_arbiter_if.sv
// hpu_cmd_arbiter_if: bundles the request, command and response buses of
// hpu_cmd_arbiter. The slave modport is the arbiter's view; the master modport
// is the view of the surrounding frontends / command unit.
// Optional macro HPU_CMD_ARB_PRIO_EN adds the per-core priority input prio_i.
interface hpu_cmd_arbiter_if #(
    parameter int NUM_CORES     = 8,
    parameter int CMD_WIDTH     = 256,
    parameter int CORE_ID_WIDTH = 4
);
    logic [NUM_CORES-1:0]           req_valid_i;
    logic [NUM_CORES-1:0]           req_ready_o;
    logic [NUM_CORES*CMD_WIDTH-1:0] req_cmd_i;
    logic                           cmd_valid_o;
    logic                           cmd_ready_i;
    logic [CMD_WIDTH-1:0]           cmd_o;
    logic [CORE_ID_WIDTH-1:0]       cmd_core_o;
    logic                           resp_valid_i;
    logic [CORE_ID_WIDTH-1:0]       resp_core_i;
    logic [NUM_CORES-1:0]           resp_valid_o;
    logic                           disable_i;
    logic                           no_pending_o;
    logic                           err_o;
`ifdef HPU_CMD_ARB_PRIO_EN
    logic [NUM_CORES-1:0]           prio_i;

    modport slave (
        input  req_valid_i, req_cmd_i, cmd_ready_i, resp_valid_i, resp_core_i, disable_i, prio_i,
        output req_ready_o, cmd_valid_o, cmd_o, cmd_core_o, resp_valid_o, no_pending_o, err_o
    );
    modport master (
        output req_valid_i, req_cmd_i, cmd_ready_i, resp_valid_i, resp_core_i, disable_i, prio_i,
        input  req_ready_o, cmd_valid_o, cmd_o, cmd_core_o, resp_valid_o, no_pending_o, err_o
    );
`else
    modport slave (
        input  req_valid_i, req_cmd_i, cmd_ready_i, resp_valid_i, resp_core_i, disable_i,
        output req_ready_o, cmd_valid_o, cmd_o, cmd_core_o, resp_valid_o, no_pending_o, err_o
    );
    modport master (
        output req_valid_i, req_cmd_i, cmd_ready_i, resp_valid_i, resp_core_i, disable_i,
        input  req_ready_o, cmd_valid_o, cmd_o, cmd_core_o, resp_valid_o, no_pending_o, err_o
    );
`endif
endinterface

// File: rtl/hpu_cmd_arbiter.sv
// hpu_cmd_arbiter: shares one cluster command unit among NUM_CORES HPU command
// frontends. Round-robin grant with a per-core cap on in-flight commands,
// completions routed back to the issuing core by core id.
// Optional macro HPU_CMD_ARB_PRIO_EN: prio_i splits eligible cores into a high
// and a low class; the high class always wins, round-robin within each class
// using the one shared pointer.
module hpu_cmd_arbiter #(
    parameter int NUM_CORES       = 8,
    parameter int CMD_WIDTH       = 256,
    parameter int CORE_ID_WIDTH   = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    hpu_cmd_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_CORES);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(MAX_OUTSTANDING);
    localparam logic [NUM_CORES-1:0] ONE_HOT0 = {{(NUM_CORES-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    state_e                 r_state, w_state_next;
    logic [IDX_W-1:0]       r_idx, w_idx_next;
    logic [IDX_W-1:0]       r_ptr, w_ptr_next;
    logic [CNT_WIDTH-1:0]   r_cnt      [NUM_CORES];
    logic [CNT_WIDTH-1:0]   w_cnt_next [NUM_CORES];
    logic [NUM_CORES-1:0]   r_resp_valid;
    logic                   r_err;
    logic                   r_no_pending;
    logic                   w_no_pending_next;
    logic [NUM_CORES-1:0]   w_elig, w_inc, w_dec;
    logic [IDX_W:0]         w_pick;
    logic                   w_grant, w_req_held, w_hs, w_drop;
    logic                   w_resp_in_range, w_resp_ok, w_resp_bad;
    logic [IDX_W-1:0]       w_resp_idx;

    // First set bit of mask at or above ptr, wrapping; MSB of the result flags "found".
    function automatic logic [IDX_W:0] pick_rr(input logic [NUM_CORES-1:0] mask,
                                               input logic [IDX_W-1:0]     ptr);
        logic [IDX_W:0] res;
        int             j;
        res = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            j   = (int'(ptr) + k) % NUM_CORES;
            res = (!res[IDX_W] && mask[j]) ? {1'b1, IDX_W'(j)} : res;
        end
        return res;
    endfunction

    assign w_grant    = (r_state == ST_GRANT);
    assign w_req_held = bus.req_valid_i[r_idx];
    // A handshake needs the granted frontend to still be requesting.
    assign w_hs       = w_grant && w_req_held && bus.cmd_ready_i;
    // Frontend withdrew while granted: protocol violation, grant is abandoned.
    assign w_drop     = w_grant && !w_req_held;

    assign w_resp_in_range = (int'(bus.resp_core_i) < NUM_CORES);
    assign w_resp_idx      = IDX_W'(bus.resp_core_i);
    assign w_resp_ok       = bus.resp_valid_i && w_resp_in_range && (r_cnt[w_resp_idx] != '0);
    assign w_resp_bad      = bus.resp_valid_i && !w_resp_ok;

    assign w_inc = w_hs      ? (ONE_HOT0 << r_idx)      : '0;
    assign w_dec = w_resp_ok ? (ONE_HOT0 << w_resp_idx) : '0;

    // Eligibility: requesting, below the in-flight cap, arbiter not disabled.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            w_elig[i] = bus.req_valid_i[i] && (r_cnt[i] < CNT_MAX) && !bus.disable_i;
        end
    end

`ifdef HPU_CMD_ARB_PRIO_EN
    logic [NUM_CORES-1:0] w_elig_hi;
    assign w_elig_hi = w_elig & bus.prio_i;
    assign w_pick    = (|w_elig_hi) ? pick_rr(w_elig_hi, r_ptr) : pick_rr(w_elig, r_ptr);
`else
    assign w_pick    = pick_rr(w_elig, r_ptr);
`endif

    // Next-state logic: Idle picks a winner, Grant holds until handshake or withdrawal.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        case (r_state)
            ST_IDLE: begin
                if (w_pick[IDX_W]) begin
                    w_state_next = ST_GRANT;
                    w_idx_next   = w_pick[IDX_W-1:0];
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (w_hs || w_drop) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_GRANT;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Pointer moves just past the core that completed a handshake.
    always_comb begin
        w_ptr_next = r_ptr;
        if (w_hs) begin
            w_ptr_next = (r_idx == IDX_W'(NUM_CORES - 1)) ? '0 : (r_idx + IDX_W'(1));
        end else begin
            w_ptr_next = r_ptr;
        end
    end

    // Outstanding counters: +1 on handshake, -1 on valid completion, both cancel.
    always_comb begin
        w_no_pending_next = 1'b1;
        for (int i = 0; i < NUM_CORES; i++) begin
            w_cnt_next[i] = r_cnt[i];
            if (w_inc[i] && !w_dec[i]) begin
                w_cnt_next[i] = r_cnt[i] + CNT_WIDTH'(1);
            end else if (w_dec[i] && !w_inc[i]) begin
                w_cnt_next[i] = r_cnt[i] - CNT_WIDTH'(1);
            end else begin
                w_cnt_next[i] = r_cnt[i];
            end
            w_no_pending_next = w_no_pending_next && (w_cnt_next[i] == '0);
        end
    end

    // FSM state and latched grant index.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
        end
    end

    // Pointer, counters, completion pulse, pending flag and sticky error.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr        <= '0;
            r_resp_valid <= '0;
            r_err        <= 1'b0;
            r_no_pending <= 1'b1;
            for (int i = 0; i < NUM_CORES; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_ptr        <= w_ptr_next;
            r_resp_valid <= w_dec;
            r_err        <= r_err || w_drop || w_resp_bad;
            r_no_pending <= w_no_pending_next;
            for (int i = 0; i < NUM_CORES; i++) begin
                r_cnt[i] <= w_cnt_next[i];
            end
        end
    end

    assign bus.cmd_valid_o  = w_grant;
    assign bus.req_ready_o  = (w_grant && bus.cmd_ready_i) ? (ONE_HOT0 << r_idx) : '0;
    assign bus.cmd_o        = bus.req_cmd_i[r_idx*CMD_WIDTH +: CMD_WIDTH];
    assign bus.cmd_core_o   = CORE_ID_WIDTH'(r_idx);
    assign bus.resp_valid_o = r_resp_valid;
    assign bus.no_pending_o = r_no_pending;
    assign bus.err_o        = r_err;

endmodule

// File: tb/tb_hpu_cmd_arbiter.sv
// tb_hpu_cmd_arbiter: directed scenarios plus a randomized run, all compared
// against a transaction-level model of the arbitration rules kept here.
module tb_hpu_cmd_arbiter;
    localparam int N  = 8;
    localparam int CW = 256;
    localparam int IW = 4;
    localparam int MO = 4;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    hpu_cmd_arbiter_if #(.NUM_CORES(N), .CMD_WIDTH(CW), .CORE_ID_WIDTH(IW)) bus ();

    hpu_cmd_arbiter #(.NUM_CORES(N), .CMD_WIDTH(CW), .CORE_ID_WIDTH(IW), .MAX_OUTSTANDING(MO)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    // stimulus
    logic [N-1:0]  v, prio;
    logic [CW-1:0] cmd_arr [N];
    logic          rdy, rvalid, dis;
    logic [IW-1:0] rcore;

    assign bus.req_valid_i  = v;
    assign bus.cmd_ready_i  = rdy;
    assign bus.resp_valid_i = rvalid;
    assign bus.resp_core_i  = rcore;
    assign bus.disable_i    = dis;
`ifdef HPU_CMD_ARB_PRIO_EN
    assign bus.prio_i       = prio;
`endif
    for (genvar g = 0; g < N; g++) begin : g_cmd
        assign bus.req_cmd_i[g*CW +: CW] = cmd_arr[g];
    end

    // model state
    int           m_cnt [N];
    int           m_ptr, m_gidx;
    bit           m_err, m_nopend;
    logic [N-1:0] m_pulse;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    function automatic logic [CW-1:0] rand_cmd();
        logic [CW-1:0] c;
        for (int i = 0; i < CW / 32; i++) c[i*32 +: 32] = $urandom;
        return c;
    endfunction

    // winner: high-priority class first, then everyone, scanning from pointer
    function automatic int m_pick();
        int j;
        if (dis) return -1;
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < N; k++) begin
                j = (m_ptr + k) % N;
                if (v[j] && m_cnt[j] < MO && (pass == 1 || prio[j])) return j;
            end
        end
        return -1;
    endfunction

    task automatic m_step();
        int nxt;
        bit hs, drop, ok;
        nxt  = m_gidx;
        hs   = (m_gidx >= 0) && v[m_gidx] && rdy;
        drop = (m_gidx >= 0) && !v[m_gidx];
        ok   = 1'b0;
        if (rvalid && int'(rcore) < N) ok = (m_cnt[rcore] > 0);
        if (drop || (rvalid && !ok)) m_err = 1'b1;
        if (m_gidx < 0) nxt = m_pick();
        else if (hs || drop) nxt = -1;
        if (hs) begin
            m_cnt[m_gidx]++;
            m_ptr = (m_gidx + 1) % N;
        end
        m_pulse = '0;
        if (ok) begin
            m_cnt[rcore]--;
            m_pulse[rcore] = 1'b1;
        end
        m_gidx  = nxt;
        m_nopend = 1'b1;
        for (int i = 0; i < N; i++) if (m_cnt[i] != 0) m_nopend = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        m_step();
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        v = '0; prio = '0; rdy = 1'b0; rvalid = 1'b0; rcore = '0; dis = 1'b0;
        for (int i = 0; i < N; i++) cmd_arr[i] = rand_cmd();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_ptr = 0; m_gidx = -1; m_err = 1'b0; m_nopend = 1'b1; m_pulse = '0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests += 5;
        if (bus.cmd_valid_o !== 1'b0)  begin n_fail++; $display("FAIL rst_cmd_valid got=%0h exp=0", bus.cmd_valid_o); end
        if (bus.req_ready_o !== 8'h00) begin n_fail++; $display("FAIL rst_req_ready got=%0h exp=0", bus.req_ready_o); end
        if (bus.resp_valid_o !== 8'h00) begin n_fail++; $display("FAIL rst_resp_valid got=%0h exp=0", bus.resp_valid_o); end
        if (bus.err_o !== 1'b0)        begin n_fail++; $display("FAIL rst_err got=%0h exp=0", bus.err_o); end
        if (bus.no_pending_o !== 1'b1) begin n_fail++; $display("FAIL rst_no_pending got=%0h exp=1", bus.no_pending_o); end
        // asynchronous reset in the middle of a grant
        v = 8'h01;
        tick();
        n_tests++;
        if (bus.cmd_valid_o !== 1'b1) begin n_fail++; $display("FAIL pre_rst_grant got=%0h exp=1", bus.cmd_valid_o); end
        #2 rst_ni = 1'b0;
        #1;
        n_tests += 2;
        if (bus.cmd_valid_o !== 1'b0) begin n_fail++; $display("FAIL async_rst_valid got=%0h exp=0", bus.cmd_valid_o); end
        if (bus.no_pending_o !== 1'b1) begin n_fail++; $display("FAIL async_rst_pend got=%0h exp=1", bus.no_pending_o); end
    endtask

    task automatic test_round_robin();
        int exp_order [6] = '{0, 3, 5, 0, 3, 5};
        int nh = 0;
        int last = 0;
        do_reset();
        v = 8'h29; rdy = 1'b1;
        for (int t = 0; t < 40 && nh < 6; t++) begin
            tick();
            if (bus.cmd_valid_o === 1'b1) begin
                n_tests += 2;
                if (bus.cmd_core_o !== IW'(exp_order[nh])) begin
                    n_fail++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", nh, bus.cmd_core_o, exp_order[nh]);
                end
                if (bus.cmd_o !== cmd_arr[exp_order[nh]]) begin
                    n_fail++; $display("FAIL rr_cmd[%0d] got=%0h exp=%0h", nh, bus.cmd_o, cmd_arr[exp_order[nh]]);
                end
                if (nh > 0) begin
                    n_tests++;
                    if (cyc - last !== 2) begin n_fail++; $display("FAIL rr_spacing got=%0d exp=2", cyc - last); end
                end
                last = cyc;
                nh++;
            end
        end
        n_tests++;
        if (nh != 6) begin n_fail++; $display("FAIL rr_timeout got=%0d exp=6", nh); end
        tick();
        v = '0;
        tick();
        n_tests += 3;
        if (bus.cmd_valid_o !== 1'b0)  begin n_fail++; $display("FAIL rr_idle got=%0h exp=0", bus.cmd_valid_o); end
        if (bus.err_o !== 1'b0)        begin n_fail++; $display("FAIL rr_err got=%0h exp=0", bus.err_o); end
        if (bus.no_pending_o !== 1'b0) begin n_fail++; $display("FAIL rr_pending got=%0h exp=0", bus.no_pending_o); end
    endtask

    task automatic test_lock();
        do_reset();
        v = 8'h04; rdy = 1'b0;
        tick();
        v = 8'h06;
        for (int i = 0; i < 5; i++) begin
            dis = (i >= 2);
            tick();
            n_tests += 4;
            if (bus.cmd_valid_o !== 1'b1)  begin n_fail++; $display("FAIL lock_valid[%0d] got=%0h exp=1", i, bus.cmd_valid_o); end
            if (bus.cmd_core_o !== 4'd2)   begin n_fail++; $display("FAIL lock_core[%0d] got=%0d exp=2", i, bus.cmd_core_o); end
            if (bus.cmd_o !== cmd_arr[2])  begin n_fail++; $display("FAIL lock_cmd[%0d] got=%0h exp=%0h", i, bus.cmd_o, cmd_arr[2]); end
            if (bus.req_ready_o !== 8'h00) begin n_fail++; $display("FAIL lock_ready[%0d] got=%0h exp=0", i, bus.req_ready_o); end
        end
        dis = 1'b0; rdy = 1'b1;
        #1;
        n_tests++;
        if (bus.req_ready_o !== 8'h04) begin n_fail++; $display("FAIL lock_hs_ready got=%0h exp=04", bus.req_ready_o); end
        tick();
        v = 8'h02;
        n_tests++;
        if (bus.cmd_valid_o !== 1'b0) begin n_fail++; $display("FAIL lock_gap got=%0h exp=0", bus.cmd_valid_o); end
        tick();
        n_tests += 2;
        if (bus.cmd_core_o !== 4'd1)   begin n_fail++; $display("FAIL lock_next got=%0d exp=1", bus.cmd_core_o); end
        if (bus.req_ready_o !== 8'h02) begin n_fail++; $display("FAIL lock_next_ready got=%0h exp=02", bus.req_ready_o); end
    endtask

    task automatic test_max_outstanding();
        int  nh = 0;
        bit  got = 1'b0;
        do_reset();
        v = 8'h01; rdy = 1'b1;
        for (int t = 0; t < 20 && nh < MO; t++) begin
            tick();
            if (bus.cmd_valid_o === 1'b1) nh++;
        end
        n_tests++;
        if (nh != MO) begin n_fail++; $display("FAIL max_fill got=%0d exp=%0d", nh, MO); end
        tick();
        for (int t = 0; t < 6; t++) begin
            tick();
            n_tests++;
            if (bus.cmd_valid_o !== 1'b0) begin n_fail++; $display("FAIL max_masked[%0d] got=%0h exp=0", t, bus.cmd_valid_o); end
        end
        rvalid = 1'b1; rcore = 4'd0;
        tick();
        rvalid = 1'b0;
        n_tests += 2;
        if (bus.resp_valid_o !== 8'h01) begin n_fail++; $display("FAIL max_resp got=%0h exp=01", bus.resp_valid_o); end
        if (bus.no_pending_o !== 1'b0)  begin n_fail++; $display("FAIL max_pending got=%0h exp=0", bus.no_pending_o); end
        for (int t = 0; t < 4 && !got; t++) begin
            tick();
            n_tests++;
            if (bus.cmd_valid_o !== (m_gidx >= 0)) begin n_fail++; $display("FAIL max_regrant_cycle got=%0h exp=%0h", bus.cmd_valid_o, m_gidx >= 0); end
            if (bus.cmd_valid_o === 1'b1) got = 1'b1;
        end
        n_tests += 2;
        if (!got) begin n_fail++; $display("FAIL max_regrant got=0 exp=1"); end
        if (bus.cmd_core_o !== 4'd0) begin n_fail++; $display("FAIL max_regrant_core got=%0d exp=0", bus.cmd_core_o); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        v = 8'h10; rdy = 1'b1;
        for (int t = 0; t < 20 && m_cnt[4] < 2; t++) tick();
        rdy = 1'b0;
        for (int t = 0; t < 5 && m_gidx != 4; t++) tick();
        rdy = 1'b1; rvalid = 1'b1; rcore = 4'd4;
        tick();
        v = '0; rdy = 1'b0; rvalid = 1'b0;
        n_tests += 3;
        if (bus.resp_valid_o !== 8'h10) begin n_fail++; $display("FAIL same_resp got=%0h exp=10", bus.resp_valid_o); end
        if (bus.no_pending_o !== 1'b0)  begin n_fail++; $display("FAIL same_pending got=%0h exp=0", bus.no_pending_o); end
        if (bus.err_o !== 1'b0)         begin n_fail++; $display("FAIL same_err got=%0h exp=0", bus.err_o); end
        // count must still be 2: two more completions pulse, the third is an error
        for (int k = 0; k < 3; k++) begin
            rvalid = 1'b1; rcore = 4'd4;
            tick();
            rvalid = 1'b0;
            n_tests += 3;
            if (bus.resp_valid_o !== ((k < 2) ? 8'h10 : 8'h00)) begin
                n_fail++; $display("FAIL same_drain_resp[%0d] got=%0h exp=%0h", k, bus.resp_valid_o, (k < 2) ? 8'h10 : 8'h00);
            end
            if (bus.no_pending_o !== (k >= 1)) begin n_fail++; $display("FAIL same_drain_pend[%0d] got=%0h exp=%0h", k, bus.no_pending_o, k >= 1); end
            if (bus.err_o !== (k == 2))        begin n_fail++; $display("FAIL same_drain_err[%0d] got=%0h exp=%0h", k, bus.err_o, k == 2); end
        end
    endtask

    task automatic test_bad_resp();
        logic [IW-1:0] bad [3] = '{4'd7, 4'd9, 4'd15};
        for (int k = 0; k < 3; k++) begin
            do_reset();
            rvalid = 1'b1; rcore = bad[k];
            tick();
            rvalid = 1'b0;
            n_tests += 2;
            if (bus.resp_valid_o !== 8'h00) begin n_fail++; $display("FAIL bad_resp[%0d] got=%0h exp=0", bad[k], bus.resp_valid_o); end
            if (bus.err_o !== 1'b1)         begin n_fail++; $display("FAIL bad_err[%0d] got=%0h exp=1", bad[k], bus.err_o); end
        end
        for (int t = 0; t < 5; t++) begin
            tick();
            n_tests++;
            if (bus.err_o !== 1'b1) begin n_fail++; $display("FAIL err_sticky[%0d] got=%0h exp=1", t, bus.err_o); end
        end
    endtask

`ifdef HPU_CMD_ARB_PRIO_EN
    task automatic test_prio();
        int exp_core [3] = '{4, 1, 4};
        do_reset();
        v = 8'h12; prio = 8'h10; rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            prio = '0;
            n_tests += 2;
            if (bus.cmd_valid_o !== 1'b1) begin n_fail++; $display("FAIL prio_valid[%0d] got=%0h exp=1", k, bus.cmd_valid_o); end
            if (bus.cmd_core_o !== IW'(exp_core[k])) begin n_fail++; $display("FAIL prio_core[%0d] got=%0d exp=%0d", k, bus.cmd_core_o, exp_core[k]); end
            tick();
        end
    endtask
`endif

    task automatic test_random();
        int           cand [$];
        logic [N-1:0] e_rr;
        do_reset();
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < N; i++) begin
                if (m_gidx != i) begin
                    v[i] = ($urandom_range(0, 99) < 50);
                    if ($urandom_range(0, 3) == 0) cmd_arr[i] = rand_cmd();
                end
            end
            if (m_gidx >= 0 && $urandom_range(0, 199) == 0) v[m_gidx] = 1'b0;
            rdy = ($urandom_range(0, 99) < 60);
            dis = ($urandom_range(0, 99) < 8);
`ifdef HPU_CMD_ARB_PRIO_EN
            prio = N'($urandom);
`endif
            rvalid = ($urandom_range(0, 99) < 40);
            cand.delete();
            for (int i = 0; i < N; i++) if (m_cnt[i] > 0) cand.push_back(i);
            if (cand.size() > 0 && $urandom_range(0, 99) < 97) rcore = IW'(cand[$urandom_range(0, cand.size() - 1)]);
            else rcore = IW'($urandom_range(0, 15));
            tick();
            e_rr = (m_gidx >= 0 && rdy) ? (8'h01 << m_gidx) : 8'h00;
            n_tests += 5;
            if (bus.cmd_valid_o !== (m_gidx >= 0)) begin n_fail++; $display("FAIL rnd_valid@%0d got=%0h exp=%0h", t, bus.cmd_valid_o, m_gidx >= 0); end
            if (bus.req_ready_o !== e_rr)          begin n_fail++; $display("FAIL rnd_ready@%0d got=%0h exp=%0h", t, bus.req_ready_o, e_rr); end
            if (bus.resp_valid_o !== m_pulse)      begin n_fail++; $display("FAIL rnd_resp@%0d got=%0h exp=%0h", t, bus.resp_valid_o, m_pulse); end
            if (bus.err_o !== m_err)               begin n_fail++; $display("FAIL rnd_err@%0d got=%0h exp=%0h", t, bus.err_o, m_err); end
            if (bus.no_pending_o !== m_nopend)     begin n_fail++; $display("FAIL rnd_pend@%0d got=%0h exp=%0h", t, bus.no_pending_o, m_nopend); end
            if (m_gidx >= 0) begin
                n_tests += 2;
                if (bus.cmd_core_o !== IW'(m_gidx)) begin n_fail++; $display("FAIL rnd_core@%0d got=%0d exp=%0d", t, bus.cmd_core_o, m_gidx); end
                if (bus.cmd_o !== cmd_arr[m_gidx])  begin n_fail++; $display("FAIL rnd_cmd@%0d got=%0h exp=%0h", t, bus.cmd_o, cmd_arr[m_gidx]); end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_lock();
        test_max_outstanding();
        test_same_cycle();
        test_bad_resp();
`ifdef HPU_CMD_ARB_PRIO_EN
        test_prio();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
